// File: rtl/spi_pkg.sv
// Shared definitions for the SPI byte engine: default frame width and FSM state encoding.
package spi_pkg;

    localparam int unsigned SPI_DATA_W = 8;

    // Encoding is fixed so that state values stay stable across tools and debug dumps.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLead  = 2'd1,
        StShift = 2'd2,
        StTrail = 2'd3
    } spi_state_e;

    // Bit counter must reach DATA_W itself, hence one bit more than $clog2.
    function automatic int unsigned spi_cnt_width(input int unsigned data_w);
        return $clog2(data_w) + 1;
    endfunction

endpackage

// File: rtl/spi_byte_engine_if.sv
// Request/response and SPI pin bundle between a controller and the SPI byte engine.
interface spi_byte_engine_if
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W = SPI_DATA_W
);

    logic              tick;
    logic              start;
    logic [DATA_W-1:0] tx_data;
    logic              cs_hold;
    logic              miso;
    logic              sck;
    logic              mosi;
    logic              cs_n;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rx_data;

    // Controller side: issues frames and ticks, drives the flash data line.
    modport master (
        output tick, start, tx_data, cs_hold, miso,
        input  sck, mosi, cs_n, busy, done, rx_data
    );

    // Engine side.
    modport slave (
        input  tick, start, tx_data, cs_hold, miso,
        output sck, mosi, cs_n, busy, done, rx_data
    );

endinterface

// File: rtl/spi_byte_engine.sv
// Mode-0 SPI frame engine: shifts one DATA_W frame out on mosi and in from miso,
// advancing on upstream half-period ticks, with optional chip-select hold between frames.
module spi_byte_engine
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W = SPI_DATA_W
) (
    input logic              clk_in,
    input logic              rst,
    spi_byte_engine_if.slave bus
);

    localparam int unsigned CNT_W = spi_cnt_width(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    spi_state_e        state_q, state_d;
    logic              sck_q, sck_d;
    logic              mosi_q, mosi_d;
    logic              cs_n_q, cs_n_d;
    logic              done_q, done_d;
    logic              hold_q, hold_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;

    // State register; reset wins over start and tick.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q    <= StIdle;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            done_q     <= 1'b0;
            hold_q     <= 1'b0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            bit_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            sck_q      <= sck_d;
            mosi_q     <= mosi_d;
            cs_n_q     <= cs_n_d;
            done_q     <= done_d;
            hold_q     <= hold_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

    // Next-state logic: start is taken in IDLE regardless of tick; all else waits for tick.
    always_comb begin
        state_d    = state_q;
        sck_d      = sck_q;
        mosi_d     = mosi_q;
        cs_n_d     = cs_n_q;
        done_d     = 1'b0;
        hold_d     = hold_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        bit_cnt_d  = bit_cnt_q;

        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d    = StLead;
                    cs_n_d     = 1'b0;
                    tx_shift_d = bus.tx_data;
                    mosi_d     = bus.tx_data[DATA_W-1];
                    hold_d     = bus.cs_hold;
                    rx_shift_d = '0;
                    bit_cnt_d  = '0;
                end
            end
            StLead: begin
                // One half-period of setup before the first rising edge.
                if (bus.tick) begin
                    state_d   = StShift;
                    sck_d     = 1'b0;
                    bit_cnt_d = '0;
                end
            end
            StShift: begin
                if (bus.tick) begin
                    if (!sck_q) begin
                        sck_d      = 1'b1;
                        rx_shift_d = {rx_shift_q[DATA_W-2:0], bus.miso};
                    end else begin
                        sck_d      = 1'b0;
                        tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
                        mosi_d     = tx_shift_q[DATA_W-2];
                        bit_cnt_d  = bit_cnt_q + CNT_ONE;
                        if (bit_cnt_q == LAST_BIT) begin
                            state_d = StTrail;
                        end
                    end
                end
            end
            StTrail: begin
                // Final half-period of hold before releasing (or keeping) chip select.
                if (bus.tick) begin
                    state_d   = StIdle;
                    done_d    = 1'b1;
                    rx_data_d = rx_shift_q;
                    cs_n_d    = !hold_q;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.sck     = sck_q;
    assign bus.mosi    = mosi_q;
    assign bus.cs_n    = cs_n_q;
    assign bus.busy    = (state_q != StIdle);
    assign bus.done    = done_q;
    assign bus.rx_data = rx_data_q;

endmodule

// File: tb/tb_spi_byte_engine.sv
// Randomized scoreboard bench for spi_byte_engine: stimulus pushes the expected frame
// result, a negedge monitor reconstructs each frame from the pins and compares at done.
module tb_spi_byte_engine;
    import spi_pkg::*;

    localparam int W           = SPI_DATA_W;
    localparam int FRAME_TICKS = 2 * W + 2;

    typedef struct {
        logic [W-1:0] tx;
        logic [W-1:0] rx;
        logic         hold;
    } exp_t;

    logic clk_in = 1'b0;
    logic rst    = 1'b1;

    spi_byte_engine_if #(.DATA_W(W)) bus ();

    spi_byte_engine #(.DATA_W(W)) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    exp_t         exp_q[$];
    int           checks = 0;
    int           errors = 0;

    // Flash model: either loopback or a per-frame pattern presented MSB first.
    logic         loop    = 1'b0;
    logic [W-1:0] miso_sh = '0;
    assign bus.miso = loop ? bus.mosi : miso_sh[W-1];

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, req, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic         rst_prev = 1'b1;
    logic         sck_prev = 1'b0;
    logic         active   = 1'b0;
    logic         cs_exp   = 1'b1;
    int           ticks    = 0;
    int           rises    = 0;
    logic [W-1:0] mosi_cap = '0;

    always @(negedge clk_in) begin
        exp_t e;
        if (rst_prev) begin
            check_eq("rst_cs_n", 32'(bus.cs_n), 32'd1);
            check_eq("rst_sck", 32'(bus.sck), 32'd0);
            check_eq("rst_busy", 32'(bus.busy), 32'd0);
            check_eq("rst_done", 32'(bus.done), 32'd0);
            check_eq("rst_mosi", 32'(bus.mosi), 32'd0);
            check_eq("rst_rx_data", 32'(bus.rx_data), 32'd0);
            active = 1'b0;
            cs_exp = 1'b1;
        end else begin
            if (bus.done) begin
                check_eq("frame_pending_at_done", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_eq("rx_data", 32'(bus.rx_data), 32'(e.rx));
                    check_eq("mosi_bits", 32'(mosi_cap), 32'(e.tx));
                    check_eq("sck_rises", 32'(rises), 32'(W));
                    check_eq("ticks_to_done", 32'(ticks), 32'(FRAME_TICKS));
                    cs_exp = ~e.hold;
                end
                active = 1'b0;
            end
            check_eq("cs_n", 32'(bus.cs_n), 32'(cs_exp));
            if (active) begin
                if (bus.sck && !sck_prev) begin
                    mosi_cap = {mosi_cap[W-2:0], bus.mosi};
                    rises++;
                    miso_sh = miso_sh << 1;
                end
                if (bus.tick) ticks++;
            end else begin
                check_eq("sck_low_outside_frame", 32'(bus.sck), 32'd0);
            end
        end
        if (!rst && bus.start && !bus.busy) begin
            active   = 1'b1;
            ticks    = 0;
            rises    = 0;
            mosi_cap = '0;
            cs_exp   = 1'b0;
        end
        rst_prev = rst;
        sck_prev = bus.sck;
    end

    // ---------------- stimulus ----------------
    int phase    = 0;
    int period   = 2;
    bit rand_tick = 1'b0;

    task automatic step();
        @(posedge clk_in);
        #1;
        phase++;
        bus.tick  = rand_tick ? ($urandom_range(0, 2) == 0) : ((phase % period) == 0);
        bus.start = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] tx, input logic hold, input logic lb,
                        input logic [W-1:0] pat);
        int n = 0;
        while (bus.busy && n < 1000) begin
            step();
            n++;
        end
        check_eq("idle_before_start", 32'(bus.busy), 32'd0);
        bus.start   = 1'b1;
        bus.tx_data = tx;
        bus.cs_hold = hold;
        loop        = lb;
        miso_sh     = pat;
        exp_q.push_back('{tx: tx, rx: (lb ? tx : pat), hold: hold});
        step();
    endtask

    task automatic wait_done();
        int n = 0;
        while (!bus.done && n < 2000) begin
            step();
            n++;
        end
        check_eq("done_within_budget", 32'(bus.done), 32'd1);
    endtask

    initial begin
        bus.tick    = 1'b0;
        bus.start   = 1'b0;
        bus.tx_data = '0;
        bus.cs_hold = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();

        // Loopback, tick every 2nd cycle.
        period = 2;
        send(8'hA5, 1'b0, 1'b1, 8'h00);
        wait_done();
        check_eq("loopback_rx", 32'(bus.rx_data), 32'hA5);

        // All-ones flash data against an all-zero frame.
        send(8'h00, 1'b0, 1'b0, 8'hFF);
        wait_done();

        // Start coincides with a tick: that tick must not advance the frame.
        while (!bus.tick) step();
        send(8'h96, 1'b0, 1'b0, 8'h3D);
        wait_done();

        // Held chip select across back-to-back frames, then released.
        send(8'h03, 1'b1, 1'b0, 8'hC8);
        wait_done();
        send(8'h5A, 1'b0, 1'b0, 8'h71);
        wait_done();
        repeat (2) step();
        check_eq("cs_released_after_pair", 32'(bus.cs_n), 32'd1);

        // Start while busy must be dropped.
        send(8'h3C, 1'b0, 1'b0, 8'hE4);
        repeat (5) step();
        bus.start   = 1'b1;
        bus.tx_data = 8'hFF;
        step();
        wait_done();
        repeat (4) step();

        // Reset mid-frame with cs hold requested.
        send(8'hC3, 1'b1, 1'b0, 8'h18);
        repeat (12) step();
        rst = 1'b1;
        exp_q.delete();
        step();
        check_eq("abort_cs_n", 32'(bus.cs_n), 32'd1);
        check_eq("abort_sck", 32'(bus.sck), 32'd0);
        check_eq("abort_busy", 32'(bus.busy), 32'd0);
        repeat (2) step();
        rst = 1'b0;
        step();

        // Randomized frames, tick cadences and gaps.
        for (int i = 0; i < 24; i++) begin
            rand_tick = ($urandom_range(0, 1) == 1);
            period    = int'($urandom_range(2, 4));
            send(W'($urandom), ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0),
                 W'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                wait_done();
                repeat ($urandom_range(0, 3)) step();
            end
        end

        begin
            int n = 0;
            while ((exp_q.size() != 0 || bus.busy) && n < 3000) begin
                step();
                n++;
            end
        end
        check_eq("all_frames_completed", 32'(exp_q.size()), 32'd0);
        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
